// File: rtl/hexdisp_scan_pkg.sv
// Shared constants for the hex display scanner: segment table and
// staging/display record layout.
package hexdisp_scan_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef struct packed {
    logic [7:0]  dp;
    logic [31:0] val;
  } disp_t;

endpackage

// File: rtl/hex7seg_decode.sv
// Hex nibble to active-high 7-segment pattern {g,f,e,d,c,b,a}.
// Purely combinational.
module hex7seg_decode
  import hexdisp_scan_pkg::*;
(
  input  logic [DIGIT_W-1:0] nib_i,
  output logic [6:0]         seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (nib_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
    endcase
  end

endmodule

// File: rtl/hexdisp_scan.sv
// Time-multiplexed 8-digit hex display driver with frame-aligned
// (tear-free) value updates and optional leading-zero blanking.
module hexdisp_scan
  import hexdisp_scan_pkg::*;
#(
  parameter int NDIGIT   = 8,
  parameter int DIV      = 1024,
  parameter int BLANK_LZ = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [31:0]       val,
  input  logic [7:0]        dp,
  output logic [7:0]        seg_n,
  output logic [NDIGIT-1:0] dig_n,
  output logic              frame
);

  localparam int IW = (NDIGIT > 1) ? $clog2(NDIGIT) : 1;
  localparam int PW = $clog2(DIV);

  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  disp_t             stage_q, stage_d;
  disp_t             disp_q, disp_d;
  logic              pend_q, pend_d;
  logic [7:0]        seg_q, seg_d;
  logic [NDIGIT-1:0] dig_q, dig_d;
  logic              frame_q;

  logic              wrap;
  logic              bound;
  logic [DIGIT_W-1:0] nib;
  logic              dp_bit;
  logic [IW-1:0]     msd;
  logic              lit;
  logic [6:0]        seg_raw;

  hex7seg_decode u_dec (
    .nib_i (nib),
    .seg_o (seg_raw)
  );

  always_comb begin
    wrap  = (presc_q == PW'(DIV - 1));
    bound = wrap && (idx_q == IW'(NDIGIT - 1));

    presc_d = wrap ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (wrap)
      idx_d = (idx_q == IW'(NDIGIT - 1)) ? '0 : idx_q + 1'b1;

    stage_d = stage_q;
    pend_d  = pend_q;
    disp_d  = disp_q;
    if (load) begin
      stage_d = '{dp: dp, val: val};
      pend_d  = 1'b1;
    end
    // A load landing on the boundary bypasses staging entirely.
    if (bound) begin
      if (load)
        disp_d = '{dp: dp, val: val};
      else if (pend_q)
        disp_d = stage_q;
      pend_d = 1'b0;
    end
  end

  always_comb begin
    nib    = '0;
    dp_bit = 1'b0;
    msd    = '0;
    dig_d  = '1;
    for (int i = 0; i < NDIGIT; i++) begin
      if (idx_q == IW'(i)) begin
        nib    = disp_q.val[i*DIGIT_W +: DIGIT_W];
        dp_bit = disp_q.dp[i];
      end
      if (disp_q.val[i*DIGIT_W +: DIGIT_W] != '0)
        msd = IW'(i);
      if (presc_q != '0)
        dig_d[i] = (idx_q != IW'(i));
    end
    lit   = (BLANK_LZ == 0) || (idx_q <= msd);
    seg_d = 8'hFF;
    if (presc_q != '0)
      seg_d = ~{dp_bit, lit ? seg_raw : SEG_BLANK};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      disp_q  <= '0;
      pend_q  <= 1'b0;
      seg_q   <= 8'hFF;
      dig_q   <= '1;
      frame_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      frame_q <= bound;
    end
  end

  assign seg_n = seg_q;
  assign dig_n = dig_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_hexdisp_scan.sv
// Directed + random bench for hexdisp_scan against a cycle-count
// reference model of the scan, staging and blanking rules.
module tb_hexdisp_scan;

  localparam int ND  = 8;
  localparam int DV  = 4;
  localparam int FR  = ND * DV;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          load  = 1'b0;
  logic [31:0]   val   = '0;
  logic [7:0]    dp    = '0;
  logic [7:0]    seg_n, seg0_n;
  logic [ND-1:0] dig_n, dig0_n;
  logic          frame, frame0;

  int tests = 0;
  int fails = 0;

  logic [6:0] dec [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F,
                           7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C,
                           7'h39, 7'h5E, 7'h79, 7'h71};

  int          mcnt  = 0;
  logic [31:0] mdv   = '0;
  logic [7:0]  mdd   = '0;
  logic [31:0] msv   = '0;
  logic [7:0]  msd_s = '0;
  bit          mpend = 0;

  hexdisp_scan #(.NDIGIT(ND), .DIV(DV), .BLANK_LZ(1)) dut (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .val   (val),
    .dp    (dp),
    .seg_n (seg_n),
    .dig_n (dig_n),
    .frame (frame)
  );

  hexdisp_scan #(.NDIGIT(ND), .DIV(DV), .BLANK_LZ(0)) dut0 (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .val   (val),
    .dp    (dp),
    .seg_n (seg0_n),
    .dig_n (dig0_n),
    .frame (frame0)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int mpos();
    return mcnt % FR;
  endfunction

  task automatic step();
    int pos, ps, ix, top;
    bit bnd;
    logic [3:0] nb;
    logic [7:0] es, es0, ed;
    logic ef;
    @(posedge clock);
    pos = mpos();
    ps  = pos % DV;
    ix  = pos / DV;
    bnd = (pos == FR - 1);
    if (reset) begin
      es = 8'hFF; es0 = 8'hFF; ed = 8'hFF; ef = 1'b0;
      mcnt = 0; mdv = '0; mdd = '0;
      msv = '0; msd_s = '0; mpend = 0;
    end else begin
      ef = bnd;
      es = 8'hFF; es0 = 8'hFF; ed = 8'hFF;
      if (ps != 0) begin
        top = 0;
        for (int i = 0; i < ND; i++)
          if (((mdv >> (4 * i)) & 32'hF) != 0) top = i;
        nb  = 4'((mdv >> (4 * ix)) & 32'hF);
        ed  = ~(8'd1 << ix);
        es0 = ~{mdd[ix], dec[nb]};
        es  = (ix > top) ? ~{mdd[ix], 7'h00} : es0;
      end
      if (bnd) begin
        if (load) begin mdv = val; mdd = dp; end
        else if (mpend) begin mdv = msv; mdd = msd_s; end
        mpend = 0;
      end
      if (load) begin
        msv = val; msd_s = dp;
        if (!bnd) mpend = 1;
      end
      mcnt++;
    end
    #1;
    chk("seg_n", seg_n, es);
    chk("dig_n", dig_n, ed);
    chk("frame", {7'd0, frame}, {7'd0, ef});
    chk("seg_n_nolz", seg0_n, es0);
  endtask

  task automatic advance_to(input int p);
    for (int k = 0; k < FR + 1 && mpos() != p; k++) step();
    if (mpos() != p) chk("advance_timeout", 8'(mpos()), 8'(p));
  endtask

  task automatic load_at(input int p, input logic [31:0] v,
                         input logic [7:0] d);
    advance_to(p);
    val = v; dp = d; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic chk_digit(input string tag, input int d, input bit nolz,
                           input logic [7:0] exp);
    logic [7:0] want;
    bit hit;
    want = ~(8'd1 << d);
    hit = 0;
    for (int k = 0; k < FR + 2 && !hit; k++) begin
      step();
      if (dig_n === want) begin
        chk(tag, nolz ? seg0_n : seg_n, exp);
        hit = 1;
      end
    end
    if (!hit) chk({tag, "_timeout"}, dig_n, want);
  endtask

  initial begin
    step(); step();
    reset = 1'b0;

    chk_digit("t1_d0", 0, 0, 8'hC0);
    chk_digit("t1_d1", 1, 0, 8'hFF);
    chk_digit("t1_d7", 7, 0, 8'hFF);

    load_at(5, 32'h0000_00A5, 8'h00);
    chk_digit("t2_d1_old", 1, 0, 8'hFF);
    advance_to(0);
    chk_digit("t2_d0", 0, 0, 8'h92);
    chk_digit("t2_d1", 1, 0, 8'h88);
    chk_digit("t2_d2", 2, 0, 8'hFF);

    load_at(3, 32'h0000_0010, 8'h01);
    advance_to(0);
    chk_digit("t3_d0", 0, 1, 8'h40);
    chk_digit("t3_d1", 1, 1, 8'hF9);
    chk_digit("t3_d2", 2, 1, 8'hC0);

    load_at(2, 32'h1234_5678, 8'h00);
    load_at(6, 32'h8765_4321, 8'h00);
    advance_to(0);
    chk_digit("t4_d0", 0, 0, 8'hF9);
    chk_digit("t4_d7", 7, 0, 8'h80);

    load_at(FR - 1, 32'hFFFF_FFFF, 8'h00);
    chk_digit("t5_d0", 0, 0, 8'h8E);
    chk_digit("t5_d7", 7, 0, 8'h8E);

    load_at(4, 32'h0000_0F00, 8'h00);
    advance_to(3 * DV + 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_digit("t6_d0", 0, 0, 8'hC0);
    chk_digit("t6_d2", 2, 0, 8'hFF);

    for (int n = 0; n < 600; n++) begin
      load  = ($urandom_range(0, 5) == 0);
      val   = $urandom >> $urandom_range(0, 31);
      dp    = 8'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    load = 1'b0;
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
